// File: rtl/cache_line_mover.sv
// Refill/writeback engine between cache controller, data RAM and memory.
// Optionally writes back a dirty victim line, then fetches the new line.
module cache_line_mover #(
  parameter int DATA_WIDTH      = 8,
  parameter int CACHE_ADDR_SIZE = 10,
  parameter int MEM_ADDR_SIZE   = 16,
  parameter int LINE_WORDS_LOG2 = 2
) (
  input  logic                                       Clk,
  input  logic                                       Reset,
  input  logic                                       ReqValid,
  output logic                                       ReqReady,
  input  logic                                       ReqDirty,
  input  logic [CACHE_ADDR_SIZE-LINE_WORDS_LOG2-1:0] ReqLine,
  input  logic [MEM_ADDR_SIZE-LINE_WORDS_LOG2-1:0]   ReqVictimBase,
  input  logic [MEM_ADDR_SIZE-LINE_WORDS_LOG2-1:0]   ReqFillBase,
  output logic                                       Done,
  output logic [CACHE_ADDR_SIZE-1:0]                 RamAddress,
  output logic [DATA_WIDTH-1:0]                      RamDataIn,
  output logic                                       RamWrite,
  input  logic [DATA_WIDTH-1:0]                      RamDataOut,
  output logic [MEM_ADDR_SIZE-1:0]                   MemAddress,
  output logic [DATA_WIDTH-1:0]                      MemWrData,
  output logic                                       MemRead,
  output logic                                       MemWrite,
  input  logic                                       MemAck,
  input  logic [DATA_WIDTH-1:0]                      MemRdData
);

  localparam int LWL = LINE_WORDS_LOG2;
  localparam int LA  = CACHE_ADDR_SIZE - LWL;
  localparam int MA  = MEM_ADDR_SIZE - LWL;
  localparam logic [LWL-1:0] ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_RD,
    S_WB_MEM,
    S_FILL_MEM,
    S_FILL_WR,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_n;
  logic [LWL-1:0] idx;
  logic [LWL-1:0] idx_n;
  logic [LA-1:0]  line_q;
  logic [LA-1:0]  line_n;
  logic [MA-1:0]  victim_q;
  logic [MA-1:0]  victim_n;
  logic [MA-1:0]  fill_q;
  logic [MA-1:0]  fill_n;

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    line_n   = line_q;
    victim_n = victim_q;
    fill_n   = fill_q;
    unique case (state)
      S_IDLE: begin
        if (ReqValid) begin
          state_n  = ReqDirty ? S_WB_RD : S_FILL_MEM;
          idx_n    = '0;
          line_n   = ReqLine;
          victim_n = ReqVictimBase;
          fill_n   = ReqFillBase;
        end
      end
      S_WB_RD: state_n = S_WB_MEM;
      S_WB_MEM: begin
        if (MemAck) begin
          if (&idx) begin
            idx_n   = '0;
            state_n = S_FILL_MEM;
          end else begin
            idx_n   = idx + ONE;
            state_n = S_WB_RD;
          end
        end
      end
      S_FILL_MEM: begin
        if (MemAck) state_n = S_FILL_WR;
      end
      S_FILL_WR: begin
        if (&idx) begin
          idx_n   = '0;
          state_n = S_DONE;
        end else begin
          idx_n   = idx + ONE;
          state_n = S_FILL_MEM;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so strobes align with it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      line_q     <= '0;
      victim_q   <= '0;
      fill_q     <= '0;
      ReqReady   <= 1'b1;
      Done       <= 1'b0;
      RamAddress <= '0;
      RamDataIn  <= '0;
      RamWrite   <= 1'b0;
      MemAddress <= '0;
      MemWrData  <= '0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      line_q     <= line_n;
      victim_q   <= victim_n;
      fill_q     <= fill_n;
      ReqReady   <= (state_n == S_IDLE);
      Done       <= (state_n == S_DONE);
      RamWrite   <= (state_n == S_FILL_WR);
      MemRead    <= (state_n == S_FILL_MEM);
      MemWrite   <= (state_n == S_WB_MEM);
      RamAddress <= {line_n, idx_n};
      MemAddress <= (state_n == S_WB_MEM) ? {victim_n, idx_n}
                                          : {fill_n, idx_n};
      if (state == S_WB_RD) MemWrData <= RamDataOut;
      if (state == S_FILL_MEM && MemAck) RamDataIn <= MemRdData;
    end
  end

endmodule
